adxl345_sampler: RTL and testbench
==================================

// Module: adxl345_sampler
// PURPOSE
//  Transaction sequencer directly upstream of spi_master (SPI mode 3) in the ADXL345 IMU path.
//  Drives spi_master's byte handshake and owns chip-select. After reset it writes DATA_FORMAT,
//  BW_RATE and POWER_CTL, then issues a 6-byte burst read of DATAX0..DATAZ1 every SAMPLE_PERIOD clocks.
//  It presents X/Y/Z as signed 16-bit words with a one-cycle valid strobe.
// PARAMETERS
//  SAMPLE_PERIOD    120000  clocks between read-transaction starts (100 Hz at 12 MHz); >= 64
//  CS_SETUP_CLKS    4       clocks o_cs_n is low before the first byte's o_tx_dataval; >= 1
//  CS_HOLD_CLKS     4       clocks after the last byte's i_rx_dataval before o_cs_n rises; >= 1
//  CS_IDLE_CLKS     8       minimum clocks o_cs_n stays high between transactions; >= 1
//  DATA_FORMAT_VAL  8'h0B   byte written to reg 0x31 (full-res, +/-16 g)
//  BW_RATE_VAL      8'h0A   byte written to reg 0x2C (100 Hz ODR)
// PORTS
//  i_clk           in   1   system clock, shared with spi_master
//  i_rst           in   1   synchronous, active-high reset
//  o_tx_byte       out  8   byte to spi_master
//  o_tx_dataval    out  1   one-cycle start pulse to spi_master
//  i_tx_ready      in   1   spi_master idle/ready
//  i_rx_dataval    in   1   spi_master byte-received pulse
//  i_rx_byte       in   8   spi_master received byte
//  o_cs_n          out  1   ADXL345 chip select, active low
//  o_init_done     out  1   high (sticky) after POWER_CTL write completes
//  o_sample_valid  out  1   one-cycle pulse: o_accel_* updated
//  o_accel_x       out 16   {DATAX1,DATAX0}, two's complement
//  o_accel_y       out 16   {DATAY1,DATAY0}
//  o_accel_z       out 16   {DATAZ1,DATAZ0}
// BEHAVIOUR
//  Reset: o_cs_n=1, o_tx_dataval=0, o_tx_byte=0, o_init_done=0, o_sample_valid=0, o_accel_*=0.
//   Sequencer returns to transaction T0, and all counters clear. Reset mid-byte aborts immediately,
//   with no partial sample published. spi_master must be reset by the same reset.
//  Transactions in order. Writes send address then data; rx bytes are discarded.
//   T0 {0x31, DATA_FORMAT_VAL}, T1 {0x2C, BW_RATE_VAL}, T2 {0x2D, 0x08}.
//   T3 read: 0xF2 (R=1, MB=1, addr 0x32), then six 0x00 dummy bytes. T3 repeats forever.
//  FSM: IDLE -> CS_SETUP -> SEND -> WAIT_RX -> (SEND | CS_HOLD) -> IDLE.
//   IDLE: o_cs_n=1. Leave after >= CS_IDLE_CLKS cycles; for T3, additionally wait for period expiry.
//   CS_SETUP: o_cs_n=0 for CS_SETUP_CLKS cycles.
//   SEND: o_tx_dataval=1 for exactly the one cycle in which i_tx_ready=1 is sampled; then WAIT_RX.
//   WAIT_RX: o_tx_byte held stable from the pulse cycle until i_rx_dataval (spi_master latches it
//    one cycle late). i_tx_ready is ignored here. On i_rx_dataval, store byte k and go to SEND if
//    bytes remain, else CS_HOLD.
//   CS_HOLD: o_cs_n=0 for CS_HOLD_CLKS cycles, then o_cs_n=1 and IDLE.
//  Read bytes map in order to X0,X1,Y0,Y1,Z0,Z1 in shadow regs. o_accel_* update together, and
//   o_sample_valid pulses, in the cycle o_cs_n returns high after T3.
//  o_init_done sets in the cycle o_cs_n returns high after T2.
//  Period: a free-running counter reloads at each T3 CS_SETUP entry. If it has expired at T3 end,
//   the next T3 starts after CS_IDLE_CLKS (no skipped or queued samples). The first T3 starts
//   after CS_IDLE_CLKS following T2.
//  i_rx_dataval outside WAIT_RX is ignored. o_tx_dataval is never asserted while o_cs_n=1.
// TESTING
//  1 Reset, spi_master + ADXL345 BFM (mode 3) -> MOSI byte seqs 31 0B, 2C 0A, 2D 08;
//    o_init_done rises after third CS high.
//  2 BFM returns 34 12 CC FF 00 01 -> X=16'h1234, Y=16'hFFCC, Z=16'h0100, one o_sample_valid pulse.
//  3 SAMPLE_PERIOD=200 -> consecutive T3 CS falls exactly 200 clocks apart; 5 samples, each valid one cycle.
//  4 SAMPLE_PERIOD=64, slow SPI (CLKS_PER_HALF_BIT=8) -> back-to-back T3 with CS high exactly CS_IDLE_CLKS.
//  5 Assert i_rst during 4th byte of T3 -> o_cs_n=1 next cycle, o_accel_* =0, no valid; restarts at T0.
//  6 Check every tx_dataval has cs_n=0, i_tx_ready=1, tx_byte stable until rx_dataval, CS setup/hold >= params.

Source files
------------

// File: rtl/adxl345_sampler.sv
`default_nettype none
// ============================================================================
// Module   : adxl345_sampler
// Purpose  : ADXL345 init-and-sample sequencer driving an SPI byte engine.
// Revision : 1.0 - initial release
// ============================================================================
module adxl345_sampler #(
  parameter int         SAMPLE_PERIOD   = 120000,
  parameter int         CS_SETUP_CLKS   = 4,
  parameter int         CS_HOLD_CLKS    = 4,
  parameter int         CS_IDLE_CLKS    = 8,
  parameter logic [7:0] DATA_FORMAT_VAL = 8'h0B,
  parameter logic [7:0] BW_RATE_VAL     = 8'h0A
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_dataval,
  input  logic        i_tx_ready,
  input  logic        i_rx_dataval,
  input  logic [7:0]  i_rx_byte,
  output logic        o_cs_n,
  output logic        o_init_done,
  output logic        o_sample_valid,
  output logic [15:0] o_accel_x,
  output logic [15:0] o_accel_y,
  output logic [15:0] o_accel_z
);

  localparam int C_MAX12  = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
  localparam int C_CNT_MX = (C_MAX12 > CS_IDLE_CLKS) ? C_MAX12 : CS_IDLE_CLKS;
  localparam int C_CNT_W  = $clog2(C_CNT_MX + 1);
  localparam int C_PER_W  = $clog2(SAMPLE_PERIOD + 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SEND     = 3'd2,
    ST_WAIT_RX  = 3'd3,
    ST_CS_HOLD  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic [C_PER_W-1:0]   per_q, per_d;
  logic [1:0]           txn_q, txn_d;
  logic [2:0]           idx_q, idx_d;
  logic [47:0]          shadow_q, shadow_d;
  logic [15:0]          accel_x_q, accel_x_d;
  logic [15:0]          accel_y_q, accel_y_d;
  logic [15:0]          accel_z_q, accel_z_d;
  logic                 valid_q, valid_d;
  logic                 init_done_q, init_done_d;

  logic                 is_read;
  logic [2:0]           last_idx;
  logic [7:0]           tx_byte;
  logic                 per_expired;
  logic                 idle_done;

  assign is_read     = (txn_q == 2'd3);
  assign last_idx    = is_read ? 3'd6 : 3'd1;
  assign per_expired = (per_q == '0);
  assign idle_done   = (cnt_q == C_CNT_W'(CS_IDLE_CLKS - 1));

  // Byte 0 is always the register address; the rest are data or read dummies.
  always_comb begin
    tx_byte = 8'h00;
    case (txn_q)
      2'd0:    tx_byte = (idx_q == 3'd0) ? 8'h31 : DATA_FORMAT_VAL;
      2'd1:    tx_byte = (idx_q == 3'd0) ? 8'h2C : BW_RATE_VAL;
      2'd2:    tx_byte = (idx_q == 3'd0) ? 8'h2D : 8'h08;
      default: tx_byte = (idx_q == 3'd0) ? 8'hF2 : 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    per_d       = per_expired ? per_q : per_q - C_PER_W'(1);
    txn_d       = txn_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    accel_x_d   = accel_x_q;
    accel_y_d   = accel_y_q;
    accel_z_d   = accel_z_q;
    valid_d     = 1'b0;
    init_done_d = init_done_q;
    case (state_q)
      ST_IDLE: begin
        if (!idle_done) begin
          cnt_d = cnt_q + C_CNT_W'(1);
        end else if (!is_read || per_expired) begin
          state_d = ST_CS_SETUP;
          cnt_d   = '0;
          idx_d   = 3'd0;
          if (is_read) per_d = C_PER_W'(SAMPLE_PERIOD - 1);
        end
      end
      ST_CS_SETUP: begin
        if (cnt_q == C_CNT_W'(CS_SETUP_CLKS - 1)) begin
          state_d = ST_SEND;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + C_CNT_W'(1);
        end
      end
      ST_SEND: begin
        if (i_tx_ready) state_d = ST_WAIT_RX;
      end
      ST_WAIT_RX: begin
        if (i_rx_dataval) begin
          if (is_read) begin
            for (int k = 1; k < 7; k++) begin
              if (idx_q == 3'(k)) shadow_d[8*(k-1) +: 8] = i_rx_byte;
            end
          end
          if (idx_q == last_idx) begin
            state_d = ST_CS_HOLD;
            cnt_d   = '0;
          end else begin
            state_d = ST_SEND;
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      ST_CS_HOLD: begin
        if (cnt_q == C_CNT_W'(CS_HOLD_CLKS - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          // Publishing on the CS-high transition keeps X/Y/Z coherent.
          if (is_read) begin
            accel_x_d = shadow_q[15:0];
            accel_y_d = shadow_q[31:16];
            accel_z_d = shadow_q[47:32];
            valid_d   = 1'b1;
          end else begin
            txn_d = txn_q + 2'd1;
            if (txn_q == 2'd2) init_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      per_q       <= '0;
      txn_q       <= 2'd0;
      idx_q       <= 3'd0;
      shadow_q    <= '0;
      accel_x_q   <= '0;
      accel_y_q   <= '0;
      accel_z_q   <= '0;
      valid_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      per_q       <= per_d;
      txn_q       <= txn_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      accel_x_q   <= accel_x_d;
      accel_y_q   <= accel_y_d;
      accel_z_q   <= accel_z_d;
      valid_q     <= valid_d;
      init_done_q <= init_done_d;
    end
  end

  assign o_cs_n         = (state_q == ST_IDLE);
  assign o_tx_dataval   = (state_q == ST_SEND) && i_tx_ready;
  assign o_tx_byte      = ((state_q == ST_SEND) || (state_q == ST_WAIT_RX)) ? tx_byte : 8'h00;
  assign o_init_done    = init_done_q;
  assign o_sample_valid = valid_q;
  assign o_accel_x      = accel_x_q;
  assign o_accel_y      = accel_y_q;
  assign o_accel_z      = accel_z_q;

endmodule
`default_nettype wire

// File: tb/tb_adxl345_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_adxl345_sampler
// Purpose  : Scoreboard bench for adxl345_sampler with an spi_master-like BFM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adxl345_sampler;

  localparam int PERIOD = 200;
  localparam int SETUP  = 4;
  localparam int HOLD   = 4;
  localparam int IDLE   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tx_byte;
  logic        tx_dataval;
  logic        tx_ready   = 1'b1;
  logic        rx_dataval = 1'b0;
  logic [7:0]  rx_byte    = 8'h00;
  logic        cs_n;
  logic        init_done;
  logic        sample_valid;
  logic [15:0] ax, ay, az;

  adxl345_sampler #(
    .SAMPLE_PERIOD  (PERIOD),
    .CS_SETUP_CLKS  (SETUP),
    .CS_HOLD_CLKS   (HOLD),
    .CS_IDLE_CLKS   (IDLE),
    .DATA_FORMAT_VAL(8'h0B),
    .BW_RATE_VAL    (8'h0A)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_tx_byte     (tx_byte),
    .o_tx_dataval  (tx_dataval),
    .i_tx_ready    (tx_ready),
    .i_rx_dataval  (rx_dataval),
    .i_rx_byte     (rx_byte),
    .o_cs_n        (cs_n),
    .o_init_done   (init_done),
    .o_sample_valid(sample_valid),
    .o_accel_x     (ax),
    .o_accel_y     (ay),
    .o_accel_z     (az)
  );

  always #5 clk = ~clk;

  int          vec = 0;
  int          fails = 0;
  int          exp_len_q[$];
  logic [55:0] exp_tx_q[$];
  logic [47:0] exp_smp_q[$];
  logic [7:0]  resp_q[$];
  int          lat = 3;
  int          sample_cnt = 0;
  int          cap_n = 0;
  logic        cur_read = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_write(input logic [7:0] a, input logic [7:0] d);
    exp_len_q.push_back(2);
    exp_tx_q.push_back({40'h0, d, a});
  endtask

  task automatic push_read(input logic [47:0] bytes_lo_first, input logic [15:0] x,
                           input logic [15:0] y, input logic [15:0] z);
    exp_len_q.push_back(7);
    exp_tx_q.push_back({48'h0, 8'hF2});
    for (int i = 0; i < 6; i++) resp_q.push_back(bytes_lo_first[8*i +: 8]);
    exp_smp_q.push_back({z, y, x});
  endtask

  task automatic wait_samples(input int target, input int budget);
    int n;
    n = 0;
    while (sample_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("sample_timeout", 64'(sample_cnt >= target), 64'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_cs_n", 64'(cs_n), 64'd1);
    check("rst_tx_dataval", 64'(tx_dataval), 64'd0);
    check("rst_tx_byte", 64'(tx_byte), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_valid", 64'(sample_valid), 64'd0);
    check("rst_accel", 64'({az, ay, ax}), 64'd0);
  endtask

  // Monitor first (samples DUT outputs), then the spi_master-like BFM updates its drives.
  initial begin
    int          cyc, rises, rise_cyc, fall_cyc, last_rd_fall, last_rx_cyc, cnt, l, ef;
    logic        prev_cs, prev_valid, have_rise, busy, stable_ok;
    logic        s_cs, s_dv, s_rdy;
    logic [7:0]  s_byte, held, resp;
    logic [55:0] cap, et;
    logic [47:0] es;
    cyc = 0; rises = 0; rise_cyc = 0; fall_cyc = 0; last_rd_fall = -1; last_rx_cyc = 0;
    cnt = 0; prev_cs = 1'b1; prev_valid = 1'b0; have_rise = 1'b0; busy = 1'b0;
    stable_ok = 1'b1; held = 8'h00; resp = 8'h00; cap = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        rises = 0; have_rise = 1'b0; last_rd_fall = -1; busy = 1'b0; cap_n = 0;
        cur_read = 1'b0; prev_cs = 1'b1; prev_valid = 1'b0;
        tx_ready = 1'b1; rx_dataval = 1'b0;
        continue;
      end
      s_cs = cs_n; s_dv = tx_dataval; s_rdy = tx_ready; s_byte = tx_byte;

      if (prev_cs && !s_cs) begin
        fall_cyc = cyc; cap_n = 0; cap = '0;
        cur_read = (rises >= 3);
        if (have_rise) begin
          ef = rise_cyc + IDLE;
          if (cur_read && rises >= 4 && last_rd_fall >= 0 && last_rd_fall + PERIOD > ef)
            ef = last_rd_fall + PERIOD;
          check("cs_fall_cycle", 64'(fall_cyc), 64'(ef));
        end
        if (cur_read) last_rd_fall = fall_cyc;
      end

      if (!prev_cs && s_cs) begin
        rises++; rise_cyc = cyc; have_rise = 1'b1;
        check("cs_hold", 64'((cyc - last_rx_cyc - 1) >= HOLD), 64'd1);
        check("init_done", 64'(init_done), 64'(rises >= 3));
        check("valid_at_cs_rise", 64'(sample_valid), 64'(rises >= 4));
        if (exp_len_q.size() > 0) begin
          l  = exp_len_q.pop_front();
          et = exp_tx_q.pop_front();
          check("tx_len", 64'(cap_n), 64'(l));
          check("tx_bytes", 64'(cap), 64'(et));
        end
      end

      if (sample_valid) begin
        sample_cnt++;
        check("valid_width", 64'(prev_valid), 64'd0);
        if (exp_smp_q.size() > 0) begin
          es = exp_smp_q.pop_front();
          check("accel_zyx", 64'({az, ay, ax}), 64'(es));
        end
      end
      prev_valid = sample_valid;
      prev_cs    = s_cs;

      if (rx_dataval) rx_dataval = 1'b0;
      if (busy) begin
        tx_ready = 1'b0;
        if (s_byte !== held) stable_ok = 1'b0;
        cnt--;
        if (cnt <= 0) begin
          rx_dataval = 1'b1; rx_byte = resp; tx_ready = 1'b1; busy = 1'b0;
          last_rx_cyc = cyc;
          check("tx_byte_stable", 64'(stable_ok), 64'd1);
        end
      end
      if (s_dv) begin
        check("dataval_cs_ready", 64'({s_cs, s_rdy}), 64'd1);
        if (cap_n == 0) check("cs_setup", 64'((cyc - fall_cyc) >= SETUP), 64'd1);
        if (cap_n < 7) cap[8*cap_n +: 8] = s_byte;
        if (cur_read && cap_n >= 1) resp = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
        else                        resp = 8'hA5;
        cap_n++;
        held = s_byte; busy = 1'b1; stable_ok = 1'b1; cnt = lat;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();

    push_write(8'h31, 8'h0B);
    push_write(8'h2C, 8'h0A);
    push_write(8'h2D, 8'h08);
    push_read(48'h0100_FFCC_1234, 16'h1234, 16'hFFCC, 16'h0100);
    push_read(48'h0001_7FFF_8000, 16'h8000, 16'h7FFF, 16'h0001);
    push_read(48'hA55A_0000_FFFF, 16'hFFFF, 16'h0000, 16'hA55A);
    push_read(48'hDEF0_9ABC_5678, 16'h5678, 16'h9ABC, 16'hDEF0);
    rst = 1'b0;
    wait_samples(4, 3000);

    // Slow bytes: a read outlasts the period, so reads run back to back.
    lat = 40;
    push_read(48'h6655_4433_2211, 16'h2211, 16'h4433, 16'h6655);
    push_read(48'h99AA_BBCC_DDEE, 16'hDDEE, 16'hBBCC, 16'h99AA);
    wait_samples(6, 2000);

    push_read(48'h1111_2222_3333, 16'h3333, 16'h2222, 16'h1111);
    n = 0;
    while (!(cur_read && cap_n == 4) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reach_4th_byte", 64'(cur_read && cap_n == 4), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    exp_len_q.delete(); exp_tx_q.delete(); exp_smp_q.delete(); resp_q.delete();
    lat = 3;
    push_write(8'h31, 8'h0B);
    push_write(8'h2C, 8'h0A);
    push_write(8'h2D, 8'h08);
    push_read(48'h0605_0403_0201, 16'h0201, 16'h0403, 16'h0605);
    @(negedge clk);
    check("rst_no_valid", 64'(sample_valid), 64'd0);
    rst = 1'b0;
    wait_samples(7, 1500);
    check("samples_drained", 64'(exp_smp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

endmodule
`default_nettype wire
